// File: rtl/seq_detector_multi_pkg.sv
// Shared types and helpers for the multi-pattern serial sequence detector.
package seqdet_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } chain_state_t;

    localparam int PAT_W_MAX = 16;

    // Saturating increment of a value held in the low 'width' bits (width 1..32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - width);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_multi_sat_counter.sv
// Saturating up-counter, cleared by reset or soft clear.
module sat_counter
    import seqdet_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= W'(sat_inc(32'(count), W));
        end
    end

endmodule

// File: rtl/seq_detector_multi.sv
// Two-pattern serial sequence detector with overlap and chained (A-then-B) modes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | chain not armed; in chain mode B hits are suppressed
//   ARMED | A has been seen with chain_en=1; every B hit is reported
module seq_detector_multi
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             x,
    input  logic [PAT_W-1:0] pat_a,
    input  logic [PAT_W-1:0] pat_b,
    input  logic             overlap_en,
    input  logic             chain_en,
    input  logic             clear,
    output logic             match_a,
    output logic             match_b,
    output logic             armed,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    chain_state_t      state;

    logic [PAT_W-1:0] win;
    logic             full;
    logic             hit_a;
    logic             hit_b;
    logic             report_b;
    logic             take_a;
    logic             take_b;

    assign win      = {hist, x};
    assign full     = (fill == FILL_MAX);
    assign hit_a    = full && (win == pat_a);
    assign hit_b    = full && (win == pat_b);
    // In chain mode a simultaneous A+B hit from IDLE only arms; the B hit is dropped.
    assign report_b = hit_b && (!chain_en || (state == ARMED));
    assign take_a   = in_valid && hit_a;
    assign take_b   = in_valid && report_b;
    assign armed    = (state == ARMED);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist    <= '0;
            fill    <= '0;
            state   <= IDLE;
            match_a <= 1'b0;
            match_b <= 1'b0;
        end else begin
            match_a <= take_a;
            match_b <= take_b;

            if (in_valid) begin
                hist <= win[PAT_W-2:0];
                // A reported detection restarts collection only in non-overlap mode.
                if (!overlap_en && (take_a || take_b)) begin
                    fill <= '0;
                end else if (!full) begin
                    fill <= fill + 1'b1;
                end
            end

            if (!chain_en) begin
                state <= IDLE;
            end else if (take_a) begin
                state <= ARMED;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (take_a),
        .count (cnt_a)
    );

    sat_counter #(.W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (take_b),
        .count (cnt_b)
    );

endmodule

// File: tb/tb_seq_detector_multi.sv
// Self-checking bench: directed scenarios plus randomized stream against a bit-history model.
module tb_seq_detector_multi;

    localparam int PAT_W = 3;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             x = 1'b0;
    logic [PAT_W-1:0] pat_a = '0;
    logic [PAT_W-1:0] pat_b = '0;
    logic             overlap_en = 1'b1;
    logic             chain_en = 1'b0;
    logic             clear = 1'b0;
    logic             match_a;
    logic             match_b;
    logic             armed;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: full bit history, number of bits since last restart, plain counters.
    logic [31:0] m_hist;
    int          m_nbits;
    bit          m_armed;
    int          m_ca;
    int          m_cb;
    bit          m_ma;
    bit          m_mb;

    always #5 clk = ~clk;

    seq_detector_multi #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .x          (x),
        .pat_a      (pat_a),
        .pat_b      (pat_b),
        .overlap_en (overlap_en),
        .chain_en   (chain_en),
        .clear      (clear),
        .match_a    (match_a),
        .match_b    (match_b),
        .armed      (armed),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic xv, input logic c);
        logic [31:0] mask;
        logic [31:0] w;
        bit ha, hb, rb;
        mask = (32'd1 << PAT_W) - 32'd1;
        if (r || c) begin
            m_hist = '0; m_nbits = 0; m_armed = 0;
            m_ca = 0; m_cb = 0; m_ma = 0; m_mb = 0;
            return;
        end
        m_ma = 0; m_mb = 0;
        if (v) begin
            w  = ((m_hist << 1) | 32'(xv)) & mask;
            ha = (m_nbits >= PAT_W - 1) && (w == 32'(pat_a));
            hb = (m_nbits >= PAT_W - 1) && (w == 32'(pat_b));
            rb = hb && (!chain_en || m_armed);
            m_ma = ha;
            m_mb = rb;
            if (ha) m_ca = (m_ca < CNT_MAX) ? m_ca + 1 : m_ca;
            if (rb) m_cb = (m_cb < CNT_MAX) ? m_cb + 1 : m_cb;
            if (chain_en && ha) m_armed = 1;
            if (!overlap_en && (ha || rb)) m_nbits = 0;
            else if (m_nbits < 1000) m_nbits++;
            m_hist = (m_hist << 1) | 32'(xv);
        end
        if (!chain_en) m_armed = 0;
    endtask

    task automatic cyc(input logic r, input logic v, input logic xv, input logic c);
        @(negedge clk);
        reset = r; in_valid = v; x = xv; clear = c;
        model_step(r, v, xv, c);
        @(posedge clk);
        #1;
        chk("match_a", 32'(match_a), 32'(m_ma));
        chk("match_b", 32'(match_b), 32'(m_mb));
        chk("armed",   32'(armed),   32'(m_armed));
        chk("cnt_a",   32'(cnt_a),   32'(m_ca));
        chk("cnt_b",   32'(cnt_b),   32'(m_cb));
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b1, bits[i], 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        // Reset with random inputs: all outputs must stay zero.
        do_reset();
        chk("rst_cnt_a_zero", 32'(cnt_a), 32'd0);
        chk("rst_armed_zero", 32'(armed), 32'd0);

        // Overlap: 1,0,1,0,1 on pattern 101 -> two matches.
        pat_a = 3'b101; pat_b = 3'b000; overlap_en = 1'b1; chain_en = 1'b0;
        feed(16'b10101, 5);
        chk("ovl_cnt_a", 32'(cnt_a), 32'd2);

        // Non-overlap: same stream -> one match.
        do_reset();
        overlap_en = 1'b0;
        feed(16'b10101, 5);
        chk("novl_cnt_a", 32'(cnt_a), 32'd1);

        // Chain: B before A is suppressed, then A arms, then B reports.
        do_reset();
        overlap_en = 1'b1; chain_en = 1'b1; pat_a = 3'b101; pat_b = 3'b001;
        feed(16'b001, 3);
        chk("chain_pre_cnt_b", 32'(cnt_b), 32'd0);
        feed(16'b101, 3);
        chk("chain_armed", 32'(armed), 32'd1);
        feed(16'b001, 3);
        chk("chain_cnt_b", 32'(cnt_b), 32'd1);
        chk("chain_still_armed", 32'(armed), 32'd1);

        // Saturation with gaps: 5 A matches, counter holds at 3.
        do_reset();
        chain_en = 1'b0; pat_b = 3'b000;
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'($urandom), 1'b0);
            cyc(1'b0, 1'b0, 1'($urandom), 1'b0);
        end
        chk("sat_cnt_a", 32'(cnt_a), 32'(CNT_MAX));

        // Mid-operation clear: arm first, then clear drops history and armed.
        do_reset();
        chain_en = 1'b1; pat_b = 3'b001;
        feed(16'b101, 3);
        chk("clr_pre_armed", 32'(armed), 32'd1);
        feed(16'b10, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_armed", 32'(armed), 32'd0);
        chk("clr_cnt_a", 32'(cnt_a), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clr_no_match", 32'(match_a), 32'd0);
        feed(16'b01, 2);
        chk("clr_match_a", 32'(match_a), 32'd1);

        // Randomized stream with live pattern/mode changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                pat_a = PAT_W'($urandom);
                pat_b = ($urandom_range(0, 3) == 0) ? pat_a : PAT_W'($urandom);
                overlap_en = 1'($urandom);
                chain_en = 1'($urandom);
            end
            if ($urandom_range(0, 49) == 0) chain_en = ~chain_en;
            if ($urandom_range(0, 49) == 0) overlap_en = ~overlap_en;
            cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
